// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO phase sweep front end.
// Holds state encoding, default widths and the tone-mode length code.
package nco_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PW_DEF   = 32;
  localparam int CW_DEF   = 16;
  localparam int LEN_TONE = 0;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// Frequency-word sequencer: holds start/step/len, current freq,
// sweep counter and the first-sample flag.
// Ports: i_load captures a new config, i_adv advances one sample;
// o_freq is the increment for this sample, o_first marks sweep start.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_adv,
  input  logic [PW-1:0] i_start,
  input  logic [PW-1:0] i_step,
  input  logic [CW-1:0] i_len,
  output logic [PW-1:0] o_freq,
  output logic          o_first
);

  logic [PW-1:0] start_q, start_d;
  logic [PW-1:0] step_q, step_d;
  logic [CW-1:0] len_q, len_d;
  logic [PW-1:0] freq_q, freq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;

  always_comb begin
    start_d = start_q;
    step_d  = step_q;
    len_d   = len_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (i_load) begin
      start_d = i_start;
      step_d  = i_step;
      len_d   = i_len;
      freq_d  = i_start;
      cnt_d   = i_len;
      first_d = 1'b1;
    end else if (i_adv) begin
      first_d = 1'b0;
      if (len_q != CW'(LEN_TONE)) begin
        if (cnt_q == CW'(1)) begin
          // Sweep wraps: restart freq, keep acc running upstream.
          freq_d  = start_q;
          cnt_d   = len_q;
          first_d = 1'b1;
        end else begin
          freq_d = freq_q + step_q;
          cnt_d  = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      start_q <= '0;
      step_q  <= '0;
      len_q   <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      start_q <= start_d;
      step_q  <= step_d;
      len_q   <= len_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign o_freq  = freq_q;
  assign o_first = first_q;

endmodule

// File: rtl/nco_phase_sweep.sv
// NCO phase front end: fixed tone or repeating linear chirp.
// Ports: cfg valid/ready load, i_ce advance, i_stop abort;
// o_phase/o_aux feed the sine lookup, o_busy flags RUN.
module nco_phase_sweep
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [PW-1:0] i_cfg_start,
  input  logic [PW-1:0] i_cfg_step,
  input  logic [CW-1:0] i_cfg_len,
  input  logic [PW-1:0] i_cfg_offset,
  input  logic          i_stop,
  output logic [PW-1:0] o_phase,
  output logic          o_aux,
  output logic          o_busy
);

  state_e        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] off_q, off_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          aux_q, aux_d;
  logic          busy_q, busy_d;

  logic          load;
  logic          adv;
  logic [PW-1:0] freq;
  logic          first;

  assign o_cfg_ready = (state_q == ST_IDLE) && !i_stop && !i_reset;
  assign load = i_cfg_valid && o_cfg_ready;
  assign adv  = (state_q == ST_RUN) && i_ce && !i_stop;

  nco_sweep_ctrl #(
    .PW(PW),
    .CW(CW)
  ) u_ctrl (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_load (load),
    .i_adv  (adv),
    .i_start(i_cfg_start),
    .i_step (i_cfg_step),
    .i_len  (i_cfg_len),
    .o_freq (freq),
    .o_first(first)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    off_d   = off_q;
    phase_d = phase_q;
    aux_d   = aux_q;
    unique case (state_q)
      ST_IDLE: begin
        aux_d = 1'b0;
        if (load) begin
          acc_d   = '0;
          off_d   = i_cfg_offset;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          aux_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (i_ce) begin
          // Output is the pre-increment accumulator.
          phase_d = acc_q + off_q;
          aux_d   = first;
          acc_d   = acc_q + freq;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      off_q   <= '0;
      phase_q <= '0;
      aux_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      aux_q   <= aux_d;
      busy_q  <= busy_d;
    end
  end

  assign o_phase = phase_q;
  assign o_aux   = aux_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_nco_phase_sweep.sv
// Scoreboard bench for nco_phase_sweep: stimulus queues expected
// samples, a monitor compares each i_ce sample in RUN.
module tb_nco_phase_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start;
  logic [31:0] cfg_step;
  logic [15:0] cfg_len;
  logic [31:0] cfg_offset;
  logic        stop;
  logic [31:0] phase;
  logic        aux;
  logic        busy;

  typedef struct packed {
    logic [31:0] ph;
    logic        ax;
  } samp_t;

  samp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nco_phase_sweep dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ce        (ce),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_start (cfg_start),
    .i_cfg_step  (cfg_step),
    .i_cfg_len   (cfg_len),
    .i_cfg_offset(cfg_offset),
    .i_stop      (stop),
    .o_phase     (phase),
    .o_aux       (aux),
    .o_busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic a);
    samp_t s;
    s.ph = p;
    s.ax = a;
    sb.push_back(s);
  endtask

  // Monitor: a sample is produced on every i_ce edge in RUN.
  initial begin
    logic fire;
    samp_t s;
    forever begin
      @(posedge clk);
      fire = busy && ce && !stop && !rst;
      if (fire) begin
        #1;
        if (sb.size() == 0) begin
          chk("extra_sample", phase, 32'hxxxx_xxxx);
        end else begin
          s = sb.pop_front();
          chk("mon_phase", phase, s.ph);
          chk("mon_aux", {31'd0, aux}, {31'd0, s.ax});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic c);
    @(negedge clk);
    ce = c;
  endtask

  task automatic cfg(input logic [31:0] st, input logic [31:0] sp,
                     input logic [15:0] ln, input logic [31:0] of);
    @(negedge clk);
    ce         = 1'b1;
    cfg_start  = st;
    cfg_step   = sp;
    cfg_len    = ln;
    cfg_offset = of;
    cfg_valid  = 1'b1;
    #1 chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    ce        = 1'b0;
    chk("busy_after_cfg", {31'd0, busy}, 32'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    ce   = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; cfg_valid = 1'b0; stop = 1'b0;
    cfg_start = '0; cfg_step = '0; cfg_len = '0; cfg_offset = '0;
    repeat (2) @(negedge clk);
    chk("rst_phase", phase, 32'd0);
    chk("rst_aux", {31'd0, aux}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);

    // Tone: 17 samples with wrap back to 0.
    for (int k = 0; k < 17; k++)
      push(32'h1000_0000 * k, k == 0);
    cfg(32'h1000_0000, 32'h0, 16'd0, 32'h0);
    for (int k = 0; k < 17; k++) cyc(1'b1);
    cyc(1'b0);
    chk("tone_wrap_phase", phase, 32'h0);
    chk("ready_in_run", {31'd0, cfg_ready}, 32'd0);
    go_idle();
    drain();

    // Sweep with offset.
    push(32'h8000_0000, 1'b1);
    push(32'h8000_0100, 1'b0);
    push(32'h8000_0210, 1'b0);
    push(32'h8000_0330, 1'b1);
    push(32'h8000_0430, 1'b0);
    cfg(32'h100, 32'h10, 16'd3, 32'h8000_0000);
    repeat (5) cyc(1'b1);
    go_idle();
    drain();

    // Gated sweep: ce 1,0,0,1.
    push(32'h8000_0000, 1'b1);
    push(32'h8000_0100, 1'b0);
    cfg(32'h100, 32'h10, 16'd3, 32'h8000_0000);
    cyc(1'b1);
    cyc(1'b0);
    chk("gate_hold_ph0", phase, 32'h8000_0000);
    chk("gate_hold_aux0", {31'd0, aux}, 32'd1);
    cyc(1'b0);
    chk("gate_hold_ph1", phase, 32'h8000_0000);
    cyc(1'b1);
    chk("gate_hold_aux1", {31'd0, aux}, 32'd1);
    cyc(1'b0);
    go_idle();
    drain();

    // Negative step wrap.
    push(32'h0000_0000, 1'b1);
    push(32'h0000_0010, 1'b0);
    push(32'h0000_0010, 1'b0);
    push(32'h0000_0000, 1'b0);
    push(32'hFFFF_FFE0, 1'b1);
    push(32'hFFFF_FFF0, 1'b0);
    push(32'hFFFF_FFF0, 1'b0);
    push(32'hFFFF_FFE0, 1'b0);
    cfg(32'h10, 32'hFFFF_FFF0, 16'd4, 32'h0);
    repeat (8) cyc(1'b1);
    go_idle();
    drain();

    // Stop mid-sweep with cfg_valid high.
    push(32'h0, 1'b1);
    push(32'h100, 1'b0);
    cfg(32'h100, 32'h10, 16'd3, 32'h0);
    repeat (2) cyc(1'b1);
    @(negedge clk);
    stop      = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_phase", phase, 32'h100);
    chk("stop_aux", {31'd0, aux}, 32'd0);
    chk("stop_ready", {31'd0, cfg_ready}, 32'd0);
    @(negedge clk);
    chk("stop_no_accept", {31'd0, busy}, 32'd0);
    stop = 1'b0;
    ce   = 1'b0;
    #1 chk("ready_after_stop", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("accept_after_stop", {31'd0, busy}, 32'd1);
    drain();

    // Reset mid-RUN.
    push(32'h0, 1'b1);
    cyc(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;
    chk("mrst_phase", phase, 32'h0);
    chk("mrst_aux", {31'd0, aux}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    #1 chk("mrst_ready", {31'd0, cfg_ready}, 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
